// File: rtl/lsu.sv
// Load/store unit between the datapath and a 128-word data memory.
// Sub-word stores are done as a read-modify-write of the containing word.
module lsu (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [6:0]  dm_addr,
  output logic        dm_rd,
  output logic        dm_wr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    READ  = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [1:0]  size_r;
  logic        sign_r;
  logic [8:0]  addr_r;
  logic [31:0] wdata_r;
  logic [31:0] merge_r;
  logic        err_r;
  logic        bad_s;
  logic        unused_s;

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      2'b10:   return (a != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

  // Select the addressed lane(s) of a memory word and extend to 32 bits.
  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] lane,
                                          input logic [1:0] sz, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (sz)
      2'b00:   return {{24{sgn & b[7]}}, b};
      2'b01:   return {{16{sgn & h[15]}}, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] word, input logic [1:0] lane,
                                        input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] r;
    r = word;
    case (sz)
      2'b00:   r[{lane, 3'b000} +: 8] = wd[7:0];
      2'b01:   r[{lane[1], 4'b0000} +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  assign bad_s    = misaligned(size, addr[1:0]);
  assign unused_s = ^addr[31:9];

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req) begin
          if (bad_s)               state_s = RESP;
          else if (!we)            state_s = LOAD;
          else if (size == 2'b10)  state_s = WRITE;
          else                     state_s = READ;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD:    state_s = RESP;
      READ:    state_s = WRITE;
      WRITE:   state_s = RESP;
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Output decode; the write strobe is killed by reset within the same cycle
  always_comb begin
    stall    = ((state_r == IDLE) && req && !reset) || (state_r == LOAD) ||
               (state_r == READ) || (state_r == WRITE);
    done     = (state_r == RESP) && !reset;
    err      = (state_r == RESP) && !reset && err_r;
    dm_rd    = (state_r == LOAD) || (state_r == READ);
    dm_wr    = (state_r == WRITE) && !reset;
    dm_addr  = addr_r[8:2];
    if (size_r == 2'b10) begin
      dm_wdata = wdata_r;
    end else begin
      dm_wdata = merge_r;
    end
  end

  // State, request latches, load result and merge buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      size_r  <= 2'b00;
      sign_r  <= 1'b0;
      addr_r  <= 9'd0;
      wdata_r <= 32'd0;
      merge_r <= 32'd0;
      err_r   <= 1'b0;
      rdata   <= 32'd0;
    end else begin
      state_r <= state_s;
      if ((state_r == IDLE) && req) begin
        size_r  <= size;
        sign_r  <= sign;
        addr_r  <= addr[8:0];
        wdata_r <= wdata;
        err_r   <= bad_s;
      end
      if (state_r == LOAD) begin
        rdata <= extract(dm_rdata, addr_r[1:0], size_r, sign_r);
      end
      if (state_r == READ) begin
        merge_r <= merge(dm_rdata, addr_r[1:0], size_r, wdata_r);
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed, table-driven bench for lsu with a behavioural 128-word data memory.
module tb_lsu;
  logic        clk = 1'b0;
  logic        reset, req, we, sign;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata, dm_wdata, dm_rdata;
  logic        stall, done, err, dm_rd, dm_wr;
  logic [6:0]  dm_addr;
  logic [31:0] mem [128];
  int          total = 0;
  int          passed = 0;

  lsu dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .sign(sign),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .done(done), .err(err),
    .dm_addr(dm_addr), .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  assign dm_rdata = mem[dm_addr];
  always @(negedge clk) if (dm_wr) mem[dm_addr] <= dm_wdata;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          widx;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t vt [18];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Issue one request and follow it to done (bounded), checking stall per cycle.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic e, output logic saw_rd, output logic saw_wr);
    req = 1'b1; we = w; size = sz; sign = sg; addr = a; wdata = wd;
    lat = 0; e = 1'b0; saw_rd = 1'b0; saw_wr = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (dm_rd) saw_rd = 1'b1;
      if (dm_wr) saw_wr = 1'b1;
      chk("rd_wr_exclusive", 32'(dm_rd & dm_wr), 32'd0);
      chk("stall", 32'(stall), 32'(!done));
      if (done) begin
        lat = c;
        e = err;
        break;
      end
    end
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  initial begin
    int          lat, pulses, cyc;
    logic        e, srd, swr;
    logic [31:0] exp_b2b [2];
    for (int i = 0; i < 128; i++) mem[i] = 32'd0;

    //        we    size   sign  addr          wdata         rdata_after   err  lat widx mem_after
    vt[0]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 3, 4,   32'hDEAD_BEEF};
    vt[1]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 3, 4,   32'hDEAD_BEEF};
    vt[2]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'h0000_00AA, 32'hDEAD_BEEF, 1'b0, 4, 4,   32'hDEAD_AAEF};
    vt[3]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h80FF_1234, 32'hDEAD_BEEF, 1'b0, 3, 4,   32'h80FF_1234};
    vt[4]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0000_0000, 32'hFFFF_FF80, 1'b0, 3, 4,   32'h80FF_1234};
    vt[5]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0000_0000, 32'h0000_0080, 1'b0, 3, 4,   32'h80FF_1234};
    vt[6]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0000_0000, 32'hFFFF_80FF, 1'b0, 3, 4,   32'h80FF_1234};
    vt[7]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0000_0000, 32'h0000_80FF, 1'b0, 3, 4,   32'h80FF_1234};
    vt[8]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0010, 32'h0000_0000, 32'h0000_1234, 1'b0, 3, 4,   32'h80FF_1234};
    vt[9]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0011, 32'h0000_5555, 32'h0000_1234, 1'b1, 2, 4,   32'h80FF_1234};
    vt[10] = '{1'b0, 2'b11, 1'b1, 32'h0000_0010, 32'h0000_0000, 32'h0000_1234, 1'b1, 2, 4,   32'h80FF_1234};
    vt[11] = '{1'b0, 2'b10, 1'b0, 32'h0000_0012, 32'h0000_0000, 32'h0000_1234, 1'b1, 2, 4,   32'h80FF_1234};
    vt[12] = '{1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'h0000_5678, 32'h0000_1234, 1'b0, 4, 4,   32'h5678_1234};
    vt[13] = '{1'b1, 2'b10, 1'b0, 32'h0000_03FC, 32'h1122_3344, 32'h0000_1234, 1'b0, 3, 127, 32'h1122_3344};
    vt[14] = '{1'b0, 2'b10, 1'b0, 32'h0000_01FC, 32'h0000_0000, 32'h1122_3344, 1'b0, 3, 127, 32'h1122_3344};
    vt[15] = '{1'b0, 2'b00, 1'b0, 32'h0000_01FE, 32'h0000_0000, 32'h0000_0022, 1'b0, 3, 127, 32'h1122_3344};
    vt[16] = '{1'b1, 2'b00, 1'b1, 32'h0000_0010, 32'hFFFF_FF01, 32'h0000_0022, 1'b0, 4, 4,   32'h5678_1201};
    vt[17] = '{1'b0, 2'b00, 1'b1, 32'h0000_0010, 32'h0000_0000, 32'h0000_0001, 1'b0, 3, 4,   32'h5678_1201};

    reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sign = 1'b0;
    addr = 32'd0; wdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_ctrl", {26'd0, done, err, stall, dm_rd, dm_wr, 1'b0}, 32'd0);
    chk("reset_dm_addr", 32'(dm_addr), 32'd0);
    chk("reset_dm_wdata", dm_wdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      do_req(vt[i].we, vt[i].size, vt[i].sign, vt[i].addr, vt[i].wdata, lat, e, srd, swr);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].exp_lat));
      chk($sformatf("v%0d_err", i), 32'(e), 32'(vt[i].exp_err));
      chk($sformatf("v%0d_rdata", i), rdata, vt[i].exp_rdata);
      chk($sformatf("v%0d_mem", i), mem[vt[i].widx], vt[i].exp_mem);
      if (vt[i].exp_err) chk($sformatf("v%0d_no_mem_access", i), {30'd0, srd, swr}, 32'd0);
    end

    // sw 0x10: word address and write strobe in cycle 2
    req = 1'b1; we = 1'b1; size = 2'b10; sign = 1'b0; addr = 32'h10; wdata = 32'hCAFE_0001;
    @(negedge clk);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    chk("sw_c2_dm_addr", 32'(dm_addr), 32'd4);
    chk("sw_c2_dm_wr", 32'(dm_wr), 32'd1);
    @(negedge clk);
    chk("sw_c3_done", 32'(done), 32'd1);
    @(posedge clk); #1;
    chk("sw_mem", mem[4], 32'hCAFE_0001);

    // Reset asserted during the WRITE cycle of sw 0x10
    req = 1'b1; we = 1'b1; size = 2'b10; sign = 1'b0; addr = 32'h10; wdata = 32'h1234_5678;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_write_dm_wr", 32'(dm_wr), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; req = 1'b0;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("rst_no_done", 32'(pulses), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_dm_addr", 32'(dm_addr), 32'd0);
    chk("rst_ctrl", {29'd0, stall, dm_rd, dm_wr}, 32'd0);
    chk("rst_mem_unchanged", mem[4], 32'hCAFE_0001);
    @(posedge clk); #1;

    // Back-to-back loads with req held high across RESP
    exp_b2b[0] = 32'hCAFE_0001;
    exp_b2b[1] = 32'h1122_3344;
    req = 1'b1; we = 1'b0; size = 2'b10; sign = 1'b0; addr = 32'h10;
    pulses = 0; cyc = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      chk("b2b_stall", 32'(stall), 32'(!done));
      if (done) begin
        chk($sformatf("b2b_rdata%0d", pulses), rdata, exp_b2b[pulses]);
        pulses++;
        cyc = c;
        @(posedge clk); #1;
        if (pulses == 1) addr = 32'h1FC;
        else break;
      end
    end
    req = 1'b0;
    chk("b2b_pulses", 32'(pulses), 32'd2);
    chk("b2b_second_done_cycle", 32'(cyc), 32'd6);
    repeat (3) begin
      @(negedge clk);
      chk("b2b_no_extra_done", 32'(done), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
